sdram_ctrl_module: RTL and testbench
====================================

# sdram_ctrl_module

Sequencing stage directly upstream of the SDRAM function stage. It arbitrates host write and read requests against a periodic auto-refresh timer and drives the one-hot 3-bit `Func_Start_Sig`. Each function is held active for exactly the cycle count the function stage needs. Completion is reported to the host with one-cycle `Wr_Done_Sig` / `Rd_Done_Sig` pulses; the function stage itself has no done output.

## Interface
- `T_REF`, 1560: clocks between refresh requests (15.6 us at 100 MHz; 4096 rows / 64 ms).
- `AREF_CLKS`, 9: cycles `Func_Start_Sig[2]` is held per auto refresh.
- `RD_CLKS`, 8: cycles `Func_Start_Sig[1]` is held per read.
- `WR_CLKS`, 9: cycles `Func_Start_Sig[0]` is held per write.
- `CLK`  in  1: system clock, all logic on rising edge.
- `RSTn`  in  1: asynchronous, active-low reset.
- `Init_Done_Sig`  in  1: level; high once the SDRAM power-up/mode-register sequence is complete.
- `Wr_Req_Sig`  in  1: host write request; held high until `Wr_Done_Sig` is seen.
- `Rd_Req_Sig`  in  1: host read request; held high until `Rd_Done_Sig` is seen.
- `Wr_Done_Sig`  out  1: one-cycle pulse, write finished.
- `Rd_Done_Sig`  out  1: one-cycle pulse, read finished; function-stage `RdData` valid from this cycle until the next read.
- `Func_Start_Sig`  out  3: [2] auto refresh, [1] read, [0] write; one-hot or zero.

## Operation
- States: IDLE, AREF, WRITE, READ, DONE.
- Reset values: state IDLE, `Func_Start_Sig` = 3'b000, both Done = 0, refresh counter = 0, pending flag = 0, step counter = 0.
- Before `Init_Done_Sig`: stay in IDLE, counter held at 0, requests ignored.
- Refresh timer:
  - Counts 0..`T_REF`-1 once `Init_Done_Sig` is high, then wraps to 0.
  - At the wrap cycle it sets `ref_pending`.
  - `ref_pending` clears on the cycle IDLE enters AREF.
  - The counter runs freely during all operations.
  - A second wrap while still pending leaves the flag set; refresh requests are not queued.
- IDLE priority: `ref_pending` → AREF; else `Wr_Req_Sig` → WRITE; else `Rd_Req_Sig` → READ; else stay.
- AREF / WRITE / READ:
  - Drive the corresponding one-hot `Func_Start_Sig` for exactly N cycles (N = `AREF_CLKS` / `WR_CLKS` / `RD_CLKS`), counted by the step counter.
  - After N cycles, AREF → IDLE. WRITE and READ → DONE.
  - These states are never aborted: a new request or refresh arriving mid-operation waits.
- DONE:
  - `Func_Start_Sig` = 0.
  - Pulse the matching Done for one cycle, then go to IDLE.
- `Func_Start_Sig` is 0 in IDLE and DONE. The function stage returns its step index to 0 only via its own final step, so exact hold counts are mandatory.
- Host handshake: the host drops its request on the edge ending the Done cycle. IDLE therefore sees the request low and does not retrigger.
- Simultaneous write and read requests: the write is served first; the read is served after the following IDLE cycle.
- Reset mid-operation: everything returns to reset values immediately. The function stage shares `RSTn`, so both stages realign.

## Timing
- Write:
  - Request sampled in IDLE cycle t.
  - `Func_Start_Sig` = 001 in cycles t+1..t+9.
  - `Wr_Done_Sig` high in t+10.
  - IDLE at t+11.
- Read:
  - `Func_Start_Sig` = 010 in t+1..t+8.
  - `Rd_Done_Sig` high in t+9. The function stage latches read data at the end of t+7, so it is stable by t+9.
- Refresh: `Func_Start_Sig` = 100 in t+1..t+9, IDLE at t+10.
- Worst-case refresh latency after `ref_pending` sets: 11 cycles (one write in progress).
- Between any two operations there is at least one cycle with `Func_Start_Sig` = 0.

## Structure
- Shared package holds:
  - `Func_Start_Sig` encodings: `FUNC_AREF` = 3'b100, `FUNC_RD` = 3'b010, `FUNC_WR` = 3'b001.
  - Default cycle counts 9/8/9.
  - `T_REF` default.
- Sub-module `sdram_refresh_timer`: counter plus `ref_pending` flag, with inputs enable and clear and output pending. Counter width is ceil(log2(`T_REF`)), 11 bits at the default.
- Step counter: 4 bits, shared by all operation states, cleared on entry to each.

## Test plan
- Reset release with `Init_Done_Sig` = 0 for 3000 cycles, requests high → `Func_Start_Sig` stays 000 and no Done pulses.
- Init done, single `Wr_Req_Sig` at t → 001 for exactly 9 cycles, `Wr_Done_Sig` at t+10, no retrigger after the request drops.
- `Wr_Req_Sig` and `Rd_Req_Sig` raised the same cycle → write (9 cycles) and `Wr_Done_Sig`, then one IDLE cycle, then 010 for 8 cycles and `Rd_Done_Sig`; the function-stage model's `RdData` equals the written pattern 16'hA5C3.
- Free-running with no requests for 5 × `T_REF` → exactly 5 bursts of 100, each 9 cycles long, spaced 1560 cycles apart.
- Refresh becomes pending during cycle 3 of a write → the write completes, then Done, then IDLE, then AREF. Latency is no more than 11 cycles and no cycle has a non-one-hot `Func_Start_Sig`.
- `RSTn` asserted during cycle 5 of a read → `Func_Start_Sig` = 000 and no `Rd_Done_Sig`. After release with a request held high, a full 8-cycle read occurs.

Source files
------------

// File: rtl/sdram_ctrl_module_pkg.sv
// Shared encodings, default cycle counts and FSM state type
// for the SDRAM sequencing stage.
package sdram_ctrl_module_pkg;

    localparam logic [2:0] FUNC_NONE = 3'b000;
    localparam logic [2:0] FUNC_AREF = 3'b100;
    localparam logic [2:0] FUNC_RD   = 3'b010;
    localparam logic [2:0] FUNC_WR   = 3'b001;

    localparam int AREF_CLKS_DEF = 9;
    localparam int RD_CLKS_DEF   = 8;
    localparam int WR_CLKS_DEF   = 9;
    localparam int T_REF_DEF     = 1560;

    typedef enum logic [2:0] {
        IDLE,
        AREF,
        WRITE,
        READ,
        DONE
    } state_t;

endpackage

// File: rtl/sdram_ctrl_module_if.sv
// Host / function-stage handshake bundle of the sequencing stage.
// master = host side, slave = sequencer side.
interface sdram_ctrl_module_if;

    logic       Init_Done_Sig;
    logic       Wr_Req_Sig;
    logic       Rd_Req_Sig;
    logic       Wr_Done_Sig;
    logic       Rd_Done_Sig;
    logic [2:0] Func_Start_Sig;

    modport master (
        output Init_Done_Sig,
        output Wr_Req_Sig,
        output Rd_Req_Sig,
        input  Wr_Done_Sig,
        input  Rd_Done_Sig,
        input  Func_Start_Sig
    );

    modport slave (
        input  Init_Done_Sig,
        input  Wr_Req_Sig,
        input  Rd_Req_Sig,
        output Wr_Done_Sig,
        output Rd_Done_Sig,
        output Func_Start_Sig
    );

endinterface

// File: rtl/sdram_refresh_timer.sv
// Free-running auto-refresh interval counter with a sticky
// pending flag; a second wrap while pending is absorbed.
module sdram_refresh_timer
    import sdram_ctrl_module_pkg::*;
#(
    parameter int T_REF = T_REF_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic pending
);

    localparam int CW = $clog2(T_REF);

    logic [CW-1:0] count;
    logic          wrap;

    assign wrap = (count == CW'(T_REF - 1));

    // Interval counter and pending flag; a wrap outranks a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            pending <= 1'b0;
        end else begin
            if (!enable)
                count <= '0;
            else if (wrap)
                count <= '0;
            else
                count <= count + 1'b1;

            if (enable && wrap)
                pending <= 1'b1;
            else if (clear)
                pending <= 1'b0;
        end
    end

endmodule

// File: rtl/sdram_ctrl_module.sv
// Sequencing stage: arbitrates refresh/write/read and holds the
// one-hot function strobe for the exact step count of each op.
module sdram_ctrl_module
    import sdram_ctrl_module_pkg::*;
#(
    parameter int T_REF     = T_REF_DEF,
    parameter int AREF_CLKS = AREF_CLKS_DEF,
    parameter int RD_CLKS   = RD_CLKS_DEF,
    parameter int WR_CLKS   = WR_CLKS_DEF
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    sdram_ctrl_module_if.slave    bus
);

    localparam logic [3:0] AREF_LAST = 4'(AREF_CLKS - 1);
    localparam logic [3:0] RD_LAST   = 4'(RD_CLKS - 1);
    localparam logic [3:0] WR_LAST   = 4'(WR_CLKS - 1);

    state_t     state;
    state_t     state_n;
    logic [3:0] step;
    logic [3:0] step_n;
    logic       op_wr;
    logic       ref_pending;
    logic       ref_clear;
    logic [2:0] func;
    logic       wr_done;
    logic       rd_done;

    sdram_refresh_timer #(
        .T_REF (T_REF)
    ) u_timer (
        .clk     (CLK),
        .rst_n   (RSTn),
        .enable  (bus.Init_Done_Sig),
        .clear   (ref_clear),
        .pending (ref_pending)
    );

    // State, step counter and the op-type memory used by DONE.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= IDLE;
            step  <= 4'd0;
            op_wr <= 1'b0;
        end else begin
            state <= state_n;
            step  <= step_n;
            if (state == WRITE)
                op_wr <= 1'b1;
            else if (state == READ)
                op_wr <= 1'b0;
        end
    end

    // Next-state arbitration and strobe decode.
    always_comb begin
        state_n   = state;
        step_n    = step + 4'd1;
        func      = FUNC_NONE;
        wr_done   = 1'b0;
        rd_done   = 1'b0;
        ref_clear = 1'b0;
        unique case (state)
            IDLE: begin
                step_n = 4'd0;
                if (bus.Init_Done_Sig) begin
                    if (ref_pending) begin
                        state_n   = AREF;
                        ref_clear = 1'b1;
                    end else if (bus.Wr_Req_Sig) begin
                        state_n = WRITE;
                    end else if (bus.Rd_Req_Sig) begin
                        state_n = READ;
                    end
                end
            end
            AREF: begin
                func = FUNC_AREF;
                if (step == AREF_LAST) begin
                    state_n = IDLE;
                    step_n  = 4'd0;
                end
            end
            WRITE: begin
                func = FUNC_WR;
                if (step == WR_LAST) begin
                    state_n = DONE;
                    step_n  = 4'd0;
                end
            end
            READ: begin
                func = FUNC_RD;
                if (step == RD_LAST) begin
                    state_n = DONE;
                    step_n  = 4'd0;
                end
            end
            DONE: begin
                step_n  = 4'd0;
                state_n = IDLE;
                wr_done = op_wr;
                rd_done = !op_wr;
            end
            default: begin
                step_n  = 4'd0;
                state_n = IDLE;
            end
        endcase
    end

    assign bus.Func_Start_Sig = func;
    assign bus.Wr_Done_Sig    = wr_done;
    assign bus.Rd_Done_Sig    = rd_done;

endmodule

// File: tb/tb_sdram_ctrl_module.sv
// Bench for sdram_ctrl_module: cycle tables for write/read timing,
// plus logged runs for init gating, refresh and mid-op reset.
module tb_sdram_ctrl_module;

    localparam int T_REF = 1560;

    logic clk = 1'b0;
    logic rst_n;

    sdram_ctrl_module_if bus ();

    sdram_ctrl_module dut (
        .CLK  (clk),
        .RSTn (rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Function-stage model: step index, memory word, read latch.
    logic [3:0]  fstep;
    logic [15:0] mem;
    logic [15:0] rd_data;
    logic [15:0] wr_data;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fstep <= 4'd0;
        end else begin
            case (bus.Func_Start_Sig)
                3'b001: begin
                    if (fstep == 4'd8) begin
                        mem   <= wr_data;
                        fstep <= 4'd0;
                    end else fstep <= fstep + 4'd1;
                end
                3'b010: begin
                    if (fstep == 4'd6) rd_data <= mem;
                    if (fstep == 4'd7) fstep <= 4'd0;
                    else fstep <= fstep + 4'd1;
                end
                3'b100: begin
                    if (fstep == 4'd8) fstep <= 4'd0;
                    else fstep <= fstep + 4'd1;
                end
                default: ;
            endcase
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic       init;
        logic       wr;
        logic       rd;
        logic [2:0] func;
        logic       wd;
        logic       rdn;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic i, input logic w, input logic r,
                                input logic [2:0] f, input logic d,
                                input logic rn);
        vec_t v;
        v.init = i; v.wr = w; v.rd = r;
        v.func = f; v.wd = d; v.rdn = rn;
        tbl.push_back(v);
    endfunction

    // Cycle log of a run; index 0 unused so index i = cycle i.
    int flog[$];
    int n_wd, n_rd, first_wd, first_rd, bad_onehot, n_nz;

    task automatic run(input int n, input int wr_at, input int rd_at);
        int f;
        flog.delete();
        flog.push_back(0);
        n_wd = 0; n_rd = 0; first_wd = -1; first_rd = -1;
        bad_onehot = 0; n_nz = 0;
        for (int i = 1; i <= n; i++) begin
            @(posedge clk);
            @(negedge clk);
            f = int'(bus.Func_Start_Sig);
            flog.push_back(f);
            if (f != 0) n_nz++;
            if (f != 0 && f != 1 && f != 2 && f != 4) bad_onehot++;
            if (bus.Wr_Done_Sig) begin
                n_wd++;
                if (first_wd < 0) first_wd = i;
                bus.Wr_Req_Sig = 1'b0;
            end
            if (bus.Rd_Done_Sig) begin
                n_rd++;
                if (first_rd < 0) first_rd = i;
                bus.Rd_Req_Sig = 1'b0;
            end
            if (i == wr_at) bus.Wr_Req_Sig = 1'b1;
            if (i == rd_at) bus.Rd_Req_Sig = 1'b1;
        end
    endtask

    function automatic int first_idx(input int v, input int from);
        for (int i = from; i < flog.size(); i++)
            if (flog[i] == v) return i;
        return -1;
    endfunction

    function automatic int run_len(input int s);
        int n;
        if (s < 0) return 0;
        n = 0;
        while (s + n < flog.size() && flog[s + n] == flog[s]) n++;
        return n;
    endfunction

    task automatic do_reset(input logic init);
        @(negedge clk);
        rst_n = 1'b0;
        bus.Wr_Req_Sig = 1'b0;
        bus.Rd_Req_Sig = 1'b0;
        bus.Init_Done_Sig = init;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int s, l;
        wr_data = 16'h1234;
        rst_n = 1'b1;
        bus.Wr_Req_Sig = 1'b0;
        bus.Rd_Req_Sig = 1'b0;
        bus.Init_Done_Sig = 1'b0;

        // Reset state and init gating.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("reset_func", int'(bus.Func_Start_Sig), 0);
        check("reset_wr_done", int'(bus.Wr_Done_Sig), 0);
        check("reset_rd_done", int'(bus.Rd_Done_Sig), 0);
        do_reset(1'b0);
        run(3000, 1, 1);
        check("noinit_func_active", n_nz, 0);
        check("noinit_wr_done", n_wd, 0);
        check("noinit_rd_done", n_rd, 0);

        // Table: single write, then simultaneous write+read.
        for (int k = 0; k <= 13; k++)
            add(1, k <= 10, 0, (k <= 8) ? 3'b001 : 3'b000, k == 9, 0);
        for (int k = 0; k <= 22; k++)
            add(1, k <= 10, k <= 20,
                (k <= 8) ? 3'b001 :
                (k >= 11 && k <= 18) ? 3'b010 : 3'b000,
                k == 9, k == 19);
        do_reset(1'b1);
        for (int i = 0; i < tbl.size(); i++) begin
            if (i == 14) wr_data = 16'hA5C3;
            bus.Init_Done_Sig = tbl[i].init;
            bus.Wr_Req_Sig = tbl[i].wr;
            bus.Rd_Req_Sig = tbl[i].rd;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("tbl%0d_func", i),
                  int'(bus.Func_Start_Sig), int'(tbl[i].func));
            check($sformatf("tbl%0d_wr_done", i),
                  int'(bus.Wr_Done_Sig), int'(tbl[i].wd));
            check($sformatf("tbl%0d_rd_done", i),
                  int'(bus.Rd_Done_Sig), int'(tbl[i].rdn));
        end
        check("rd_data_pattern", int'(rd_data), 16'hA5C3);
        check("model_realigned", int'(fstep), 0);

        // Free-running refresh, five intervals.
        do_reset(1'b1);
        run(5 * T_REF + 20, -1, -1);
        s = first_idx(4, 1);
        for (int b = 0; b < 5; b++) begin
            l = run_len(s);
            check($sformatf("aref%0d_start", b), s, T_REF + 1 + b * T_REF);
            check($sformatf("aref%0d_len", b), l, 9);
            s = (s < 0) ? -1 : first_idx(4, s + l);
        end
        check("aref_no_sixth", s, -1);
        check("aref_other_func", n_nz, 45);

        // Refresh pending in cycle 3 of a write.
        do_reset(1'b1);
        run(1600, T_REF - 3, -1);
        s = first_idx(1, 1);
        check("wr_ref_wr_start", s, T_REF - 2);
        check("wr_ref_wr_len", run_len(s), 9);
        check("wr_ref_done_at", first_wd, T_REF + 7);
        check("wr_ref_done_cnt", n_wd, 1);
        s = first_idx(4, 1);
        check("wr_ref_aref_start", s, T_REF + 9);
        check("wr_ref_latency_ok", int'(s >= 0 && s - T_REF <= 11), 1);
        check("wr_ref_aref_len", run_len(s), 9);
        check("wr_ref_onehot", bad_onehot, 0);

        // Reset in cycle 5 of a read, then a full read.
        do_reset(1'b1);
        run(10, -1, 5);
        check("rst_rd_in_read", flog[10], 2);
        rst_n = 1'b0;
        #1;
        check("rst_rd_func_zero", int'(bus.Func_Start_Sig), 0);
        check("rst_rd_no_done", int'(bus.Rd_Done_Sig), 0);
        run(3, -1, -1);
        check("rst_hold_func", n_nz, 0);
        check("rst_hold_done", n_rd, 0);
        rst_n = 1'b1;
        run(12, -1, -1);
        s = first_idx(2, 1);
        check("rst_rd_restart", s, 1);
        check("rst_rd_len", run_len(s), 8);
        check("rst_rd_done_at", first_rd, 9);
        check("rst_rd_done_cnt", n_rd, 1);
        check("rst_rd_model_step", int'(fstep), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
